// File: rtl/pixel_server.sv
// Window fetcher: reads an INTEGRAL_WIDTH x INTEGRAL_HEIGHT pixel window from frame memory, row-major, zero-filling pixels outside the frame.
// Read strobe follows state; pixel k is valid two cycles after the request is accepted plus k; completion uses a 4-phase request/recieve handshake.
module pixel_server #(
  parameter int DATA_WIDTH_12              = 12,
  parameter int INTEGRAL_WIDTH             = 3,
  parameter int INTEGRAL_HEIGHT            = 3,
  parameter int FRAME_RESIZE_CAMERA_WIDTH  = 10,
  parameter int FRAME_RESIZE_CAMERA_HEIGHT = 10
) (
  input  logic                         clk_fpga,
  input  logic                         reset_fpga,
  input  logic                         i_pixel_request,
  input  logic [DATA_WIDTH_12-1:0]     i_resize_x,
  input  logic [DATA_WIDTH_12-1:0]     i_resize_y,
  output logic [2*DATA_WIDTH_12-1:0]   o_mem_addr,
  output logic                         o_mem_rden,
  input  logic [DATA_WIDTH_12-1:0]     i_mem_data,
  output logic [DATA_WIDTH_12-1:0]     o_pixel,
  output logic                         o_pixel_valid,
  output logic                         o_pixel_recieve,
  output logic                         o_busy
);

  localparam int DW = DATA_WIDTH_12;
  localparam logic [DW-1:0]   COL_LAST = DW'(INTEGRAL_WIDTH - 1);
  localparam logic [DW-1:0]   ROW_LAST = DW'(INTEGRAL_HEIGHT - 1);
  localparam logic [DW:0]     FRAME_W  = (DW+1)'(FRAME_RESIZE_CAMERA_WIDTH);
  localparam logic [DW:0]     FRAME_H  = (DW+1)'(FRAME_RESIZE_CAMERA_HEIGHT);
  localparam logic [2*DW-1:0] STRIDE   = (2*DW)'(FRAME_RESIZE_CAMERA_WIDTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ACK} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] x_q, y_q, col, row;
  logic [DW:0]   xs, ys;
  logic          in_frame, last_px, vld_q, inf_q;

  // One extra bit so an origin near the top of the range cannot wrap back into the frame.
  assign xs       = {1'b0, x_q} + {1'b0, col};
  assign ys       = {1'b0, y_q} + {1'b0, row};
  assign in_frame = (xs < FRAME_W) && (ys < FRAME_H);
  assign last_px  = (col == COL_LAST) && (row == ROW_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_pixel_request) state_nx = FETCH;
      FETCH:   if (!i_pixel_request) state_nx = IDLE;
               else if (last_px) state_nx = DRAIN;
      DRAIN:   state_nx = i_pixel_request ? ACK : IDLE;
      ACK:     if (!i_pixel_request) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state <= IDLE;
      x_q   <= '0;
      y_q   <= '0;
      col   <= '0;
      row   <= '0;
      vld_q <= 1'b0;
      inf_q <= 1'b0;
    end else begin
      state <= state_nx;
      vld_q <= (state == FETCH);
      inf_q <= (state == FETCH) && in_frame;
      case (state)
        IDLE: if (i_pixel_request) begin
          x_q <= i_resize_x;
          y_q <= i_resize_y;
          col <= '0;
          row <= '0;
        end
        FETCH: if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_rden = (state == FETCH) && in_frame;
  assign o_mem_addr = o_mem_rden
                    ? ({{(DW-1){1'b0}}, ys} * STRIDE + {{(DW-1){1'b0}}, xs})
                    : '0;

  // Gating by state suppresses the pixel still in flight when a window is aborted.
  assign o_pixel_valid   = vld_q && ((state == FETCH) || (state == DRAIN));
  assign o_pixel         = (o_pixel_valid && inf_q) ? i_mem_data : '0;
  assign o_pixel_recieve = (state == ACK);
  assign o_busy          = (state != IDLE);

endmodule

// File: tb/tb_pixel_server.sv
// Scoreboard bench for pixel_server: expected window pixels are queued by the stimulus and popped by a negedge monitor.
module tb_pixel_server;

  logic        clk_fpga = 1'b0;
  logic        reset_fpga;
  logic        i_pixel_request;
  logic [11:0] i_resize_x, i_resize_y;
  logic [23:0] o_mem_addr;
  logic        o_mem_rden;
  logic [11:0] i_mem_data;
  logic [11:0] o_pixel;
  logic        o_pixel_valid, o_pixel_recieve, o_busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int rden_cnt   = 0;
  int first_valid_cyc = -1;
  int exp_q[$];

  pixel_server dut (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga), .i_pixel_request(i_pixel_request),
    .i_resize_x(i_resize_x), .i_resize_y(i_resize_y), .o_mem_addr(o_mem_addr),
    .o_mem_rden(o_mem_rden), .i_mem_data(i_mem_data), .o_pixel(o_pixel),
    .o_pixel_valid(o_pixel_valid), .o_pixel_recieve(o_pixel_recieve), .o_busy(o_busy)
  );

  always #5 clk_fpga = ~clk_fpga;
  always @(posedge clk_fpga) cyc <= cyc + 1;

  // Memory returns the low address bits one cycle after a read; junk otherwise.
  always @(posedge clk_fpga) i_mem_data <= o_mem_rden ? o_mem_addr[11:0] : 12'hFFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk_fpga) begin
    if (o_mem_rden) rden_cnt++;
    if (o_pixel_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pixel: actual %0d, required no pixel", o_pixel);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (o_pixel !== 12'(e)) begin
          mismatched++;
          $display("FAIL pixel: actual %0d, required %0d", o_pixel, e);
        end
      end
    end
  end

  task automatic push_all(input int v[9]);
    foreach (v[i]) exp_q.push_back(v[i]);
  endtask

  task automatic full_window(input int x, input int y, input int exp_rden, input int hold);
    int c0, t;
    @(negedge clk_fpga);
    rden_cnt = 0;
    first_valid_cyc = -1;
    i_resize_x = 12'(x);
    i_resize_y = 12'(y);
    i_pixel_request = 1'b1;
    c0 = cyc;
    @(negedge clk_fpga);
    i_resize_x = 12'd7;
    i_resize_y = 12'd7;
    t = 0;
    while (!o_pixel_recieve && t < 40) begin
      @(negedge clk_fpga);
      t++;
    end
    chk("recieve_rise_cycle", cyc - c0, 11);
    chk("first_valid_cycle", first_valid_cyc - c0, 2);
    chk("rden_count", rden_cnt, exp_rden);
    chk("window_drained", exp_q.size(), 0);
    repeat (hold) @(negedge clk_fpga);
    chk("recieve_held", o_pixel_recieve, 1);
    chk("busy_in_ack", o_busy, 1);
    chk("no_rden_in_ack", rden_cnt, exp_rden);
    i_pixel_request = 1'b0;
    @(negedge clk_fpga);
    chk("recieve_drop", o_pixel_recieve, 0);
    chk("idle_after_drop", o_busy, 0);
  endtask

  initial begin
    int win_a[9] = '{32, 33, 34, 42, 43, 44, 52, 53, 54};
    int win_b[9] = '{88, 89, 0, 98, 99, 0, 0, 0, 0};
    int win_c[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int win_d[9] = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
    int c0, seen;

    reset_fpga = 1'b1;
    i_pixel_request = 1'b0;
    i_resize_x = '0;
    i_resize_y = '0;
    repeat (3) @(negedge clk_fpga);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_pixel_valid, 0);
    chk("rst_recieve", o_pixel_recieve, 0);
    chk("rst_rden", o_mem_rden, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_pixel", o_pixel, 0);
    reset_fpga = 1'b0;
    repeat (2) @(negedge clk_fpga);

    // Origin (2,3), request held 20 cycles in ACK, origin altered after acceptance.
    push_all(win_a);
    full_window(2, 3, 9, 20);
    // Partially out of frame; also a second window after drop/raise.
    push_all(win_b);
    full_window(8, 8, 4, 2);
    // Origin at the top of the coordinate range must not wrap.
    push_all(win_c);
    full_window(4095, 4095, 0, 2);

    // Abort: request low during cycle 5 of the window.
    for (int i = 0; i < 4; i++) exp_q.push_back(win_a[i]);
    @(negedge clk_fpga);
    rden_cnt = 0;
    i_resize_x = 12'd2;
    i_resize_y = 12'd3;
    i_pixel_request = 1'b1;
    c0 = cyc;
    repeat (5) @(negedge clk_fpga);
    i_pixel_request = 1'b0;
    @(negedge clk_fpga);
    chk("abort_valid_low", o_pixel_valid, 0);
    chk("abort_idle", o_busy, 0);
    chk("abort_rden_count", rden_cnt, 5);
    seen = 0;
    repeat (10) begin
      @(negedge clk_fpga);
      if (o_pixel_recieve) seen = 1;
    end
    chk("abort_no_recieve", seen, 0);
    chk("abort_no_late_rden", rden_cnt, 5);
    chk("abort_drained", exp_q.size(), 0);

    // Reset asserted during cycle 6 of a window.
    for (int i = 0; i < 5; i++) exp_q.push_back(win_d[i]);
    @(negedge clk_fpga);
    i_resize_x = 12'd0;
    i_resize_y = 12'd0;
    i_pixel_request = 1'b1;
    repeat (6) @(negedge clk_fpga);
    reset_fpga = 1'b1;
    i_pixel_request = 1'b0;
    @(negedge clk_fpga);
    chk("midrst_valid", o_pixel_valid, 0);
    chk("midrst_pixel", o_pixel, 0);
    chk("midrst_recieve", o_pixel_recieve, 0);
    chk("midrst_rden", o_mem_rden, 0);
    chk("midrst_addr", o_mem_addr, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_drained", exp_q.size(), 0);
    reset_fpga = 1'b0;
    repeat (2) @(negedge clk_fpga);
    push_all(win_d);
    full_window(0, 0, 9, 1);

    repeat (3) @(negedge clk_fpga);
    chk("final_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_server.md
PIXEL_SERVER -- requirements
Module: pixel_server

Interface
REQ-001 Parameter DATA_WIDTH_12, default 12: width of pixel and coordinate buses.
REQ-002 Parameter INTEGRAL_WIDTH, default 3: window columns.
REQ-003 Parameter INTEGRAL_HEIGHT, default 3: window rows; N = INTEGRAL_WIDTH*INTEGRAL_HEIGHT pixels per window.
REQ-004 Parameter FRAME_RESIZE_CAMERA_WIDTH, default 10: frame width in pixels.
REQ-005 Parameter FRAME_RESIZE_CAMERA_HEIGHT, default 10: frame height in pixels.
REQ-006 clk_fpga  input  1  single clock; all logic on rising edge.
REQ-007 reset_fpga  input  1  reset, synchronous, active-high.
REQ-008 i_pixel_request  input  1  level request from the window consumer.
REQ-009 i_resize_x  input  DATA_WIDTH_12  window origin column, sampled at request acceptance.
REQ-010 i_resize_y  input  DATA_WIDTH_12  window origin row, sampled at request acceptance.
REQ-011 o_mem_addr  output  2*DATA_WIDTH_12  frame memory read address = row*FRAME_RESIZE_CAMERA_WIDTH + col.
REQ-012 o_mem_rden  output  1  frame memory read strobe.
REQ-013 i_mem_data  input  DATA_WIDTH_12  read data, valid exactly 1 cycle after o_mem_rden.
REQ-014 o_pixel  output  DATA_WIDTH_12  window pixel, registered.
REQ-015 o_pixel_valid  output  1  o_pixel is valid this cycle.
REQ-016 o_pixel_recieve  output  1  window complete; held per handshake.
REQ-017 o_busy  output  1  high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, FETCH, DRAIN, ACK; unused encodings go to IDLE next cycle.
REQ-019 IDLE: on i_pixel_request=1 the block SHALL latch i_resize_x/y, clear col/row counters, go to FETCH.
REQ-020 FETCH: one pixel per cycle, row-major (col fastest), col 0..INTEGRAL_WIDTH-1, row 0..INTEGRAL_HEIGHT-1; after issuing pixel N-1 go to DRAIN.
REQ-021 Per pixel, when x+col < FRAME_RESIZE_CAMERA_WIDTH and y+row < FRAME_RESIZE_CAMERA_HEIGHT, the block SHALL assert o_mem_rden with o_mem_addr=(y+row)*FRAME_RESIZE_CAMERA_WIDTH+(x+col); otherwise o_mem_rden=0 and the pixel is out-of-frame.
REQ-022 Coordinate sums SHALL be computed at DATA_WIDTH_12+1 bits so no wrap-around masks an out-of-frame pixel.
REQ-023 The pixel issued in cycle t SHALL appear with o_pixel_valid=1 in cycle t+1; in-frame o_pixel = i_mem_data, out-of-frame o_pixel = 0.
REQ-024 Latency: request accepted at edge 0 -> pixel k valid after edge k+2; exactly N valid cycles, contiguous.
REQ-025 DRAIN: one cycle carrying last valid pixel, then ACK; o_pixel_recieve SHALL rise the cycle after the last o_pixel_valid.
REQ-026 ACK: o_pixel_recieve held 1 while i_pixel_request=1; when i_pixel_request=0 sampled, go to IDLE and drop o_pixel_recieve the next cycle (4-phase handshake).
REQ-027 A request held high through ACK SHALL NOT start a second window; a new window requires request low then high.
REQ-028 Request deasserted during FETCH or DRAIN: abort, go to IDLE next cycle, o_pixel_valid=0 from that cycle, no o_pixel_recieve pulse, no further o_mem_rden.
REQ-029 Origin changes on i_resize_x/y after acceptance SHALL have no effect on the current window.
REQ-030 o_mem_rden and o_pixel_valid SHALL never be high in IDLE or ACK.

Reset
REQ-031 reset_fpga=1 at a clock edge SHALL force IDLE and o_pixel=0, o_pixel_valid=0, o_pixel_recieve=0, o_mem_rden=0, o_mem_addr=0, o_busy=0, counters and latched origin 0.
REQ-032 Reset mid-window SHALL take priority over all transitions; no residual valid or recieve after reset.

Verification
REQ-033 Defaults, origin (2,3), memory returns addr[11:0] -> o_pixel sequence 32,33,34,42,43,44,52,53,54 on cycles 2..10, o_pixel_recieve high from cycle 11 until request drop +1.
REQ-034 Origin (8,8) -> 4 in-frame reads (88,89,98,99), 5 zeros in order 88,89,0,98,99,0,0,0,0; exactly 4 rden pulses.
REQ-035 Request held 20 cycles after completion -> single window only, recieve held, no second rden; drop then raise -> second window starts.
REQ-036 Request dropped at cycle 5 -> valid low from cycle 6, no recieve, state IDLE, no rden after cycle 5.
REQ-037 reset_fpga pulsed at cycle 6 of a window -> all outputs 0 next cycle; fresh request afterward yields full 9-pixel window.
REQ-038 Origin (4095,4095) -> all 9 pixels 0, zero rden pulses, recieve asserted normally.
